// File: rtl/mem_pair_split_pkg.sv
// Shared encodings and types for the memory-pair split stage.
package mem_pair_split_pkg;

  // Store-width encodings on the IN_store*/OUT_store* fields
  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_SB   = 2'b01;
  localparam logic [1:0] ST_SH   = 2'b10;
  localparam logic [1:0] ST_SW   = 2'b11;

  // Load-type encodings on the IN_load*/OUT_load* fields
  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LB   = 3'b001;
  localparam logic [2:0] LD_LH   = 3'b010;
  localparam logic [2:0] LD_LW   = 3'b011;
  localparam logic [2:0] LD_LBU  = 3'b100;
  localparam logic [2:0] LD_LHU  = 3'b101;

  // PASS forwards pairs; SPLIT drains the held second store
  typedef enum logic {
    PASS  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  // A slot carries a store only when it is valid and has a store encoding
  function automatic logic is_store(input logic valid, input logic [1:0] store);
    return valid & (store != ST_NONE);
  endfunction

endpackage

// File: rtl/mem_pair_split_slot_reg.sv
// One pipeline slot register (valid/store/load/payload) with load enable
// and a clear that takes priority. Invalid slots are stored with zeroed
// store/load fields so downstream never sees a phantom memory op.
module mem_slot_reg
  import mem_pair_split_pkg::*;
#(
  parameter int PW = 96
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic          d_valid,
  input  logic [1:0]    d_store,
  input  logic [2:0]    d_load,
  input  logic [PW-1:0] d_pay,
  output logic          q_valid,
  output logic [1:0]    q_store,
  output logic [2:0]    q_load,
  output logic [PW-1:0] q_pay
);

  // Slot state: reset/clear to empty, otherwise capture when enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_store <= ST_NONE;
      q_load  <= LD_NONE;
      q_pay   <= {PW{1'b0}};
    end else if (clr) begin
      q_valid <= 1'b0;
      q_store <= ST_NONE;
      q_load  <= LD_NONE;
      q_pay   <= {PW{1'b0}};
    end else if (en) begin
      q_valid <= d_valid;
      q_store <= d_valid ? d_store : ST_NONE;
      q_load  <= d_valid ? d_load  : LD_NONE;
      q_pay   <= d_pay;
    end else begin
      q_valid <= q_valid;
      q_store <= q_store;
      q_load  <= q_load;
      q_pay   <= q_pay;
    end
  end

endmodule

// File: rtl/mem_pair_split.sv
// Splits a dual-issue pair holding two stores into two single-store cycles,
// since the memory stage accepts only one store per cycle.
module mem_pair_split
  import mem_pair_split_pkg::*;
#(
  parameter int PW = 96,
  parameter int CW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          FLUSH,
  input  logic          STALL_IN,
  output logic          STALL_OUT,
  input  logic          IN_valid1,
  input  logic          IN_valid2,
  input  logic [1:0]    IN_store1,
  input  logic [1:0]    IN_store2,
  input  logic [2:0]    IN_load1,
  input  logic [2:0]    IN_load2,
  input  logic [PW-1:0] IN_pay1,
  input  logic [PW-1:0] IN_pay2,
  output logic          OUT_valid1,
  output logic          OUT_valid2,
  output logic [1:0]    OUT_store1,
  output logic [1:0]    OUT_store2,
  output logic [2:0]    OUT_load1,
  output logic [2:0]    OUT_load2,
  output logic [PW-1:0] OUT_pay1,
  output logic [PW-1:0] OUT_pay2,
  output logic [CW-1:0] split_count
);

  state_t          state_r;
  state_t          next_state_s;
  logic [CW-1:0]   split_count_r;
  logic            conflict_s;
  logic            clr_s;
  logic            out1_en_s;
  logic            out2_en_s;
  logic            hold_en_s;
  logic            hold_clr_s;
  logic            inc_s;
  logic            d1_valid_s;
  logic [1:0]      d1_store_s;
  logic [2:0]      d1_load_s;
  logic [PW-1:0]   d1_pay_s;
  logic            d2_valid_s;
  logic [1:0]      d2_store_s;
  logic [2:0]      d2_load_s;
  logic [PW-1:0]   d2_pay_s;
  logic            hold_valid_s;
  logic [1:0]      hold_store_s;
  logic [2:0]      hold_load_s;
  logic [PW-1:0]   hold_pay_s;

  assign conflict_s  = is_store(IN_valid1, IN_store1) & is_store(IN_valid2, IN_store2);
  // Upstream hold depends only on registered state and STALL_IN
  assign STALL_OUT   = (state_r == SPLIT) | STALL_IN;
  assign split_count = split_count_r;

  // Next-state and slot-mux decode; FLUSH beats STALL_IN beats normal flow
  always_comb begin
    next_state_s = state_r;
    clr_s        = 1'b0;
    out1_en_s    = 1'b0;
    out2_en_s    = 1'b0;
    hold_en_s    = 1'b0;
    hold_clr_s   = 1'b0;
    inc_s        = 1'b0;
    d1_valid_s   = IN_valid1;
    d1_store_s   = IN_store1;
    d1_load_s    = IN_load1;
    d1_pay_s     = IN_pay1;
    d2_valid_s   = IN_valid2;
    d2_store_s   = IN_store2;
    d2_load_s    = IN_load2;
    d2_pay_s     = IN_pay2;
    if (FLUSH) begin
      next_state_s = PASS;
      clr_s        = 1'b1;
    end else if (STALL_IN) begin
      next_state_s = state_r;
    end else begin
      case (state_r)
        PASS: begin
          out1_en_s = 1'b1;
          out2_en_s = 1'b1;
          if (conflict_s) begin
            d2_valid_s   = 1'b0;
            d2_store_s   = ST_NONE;
            d2_load_s    = LD_NONE;
            d2_pay_s     = {PW{1'b0}};
            hold_en_s    = 1'b1;
            inc_s        = 1'b1;
            next_state_s = SPLIT;
          end else begin
            next_state_s = PASS;
          end
        end
        SPLIT: begin
          out1_en_s    = 1'b1;
          out2_en_s    = 1'b1;
          d1_valid_s   = 1'b0;
          d1_store_s   = ST_NONE;
          d1_load_s    = LD_NONE;
          d1_pay_s     = {PW{1'b0}};
          d2_valid_s   = hold_valid_s;
          d2_store_s   = hold_store_s;
          d2_load_s    = hold_load_s;
          d2_pay_s     = hold_pay_s;
          hold_clr_s   = 1'b1;
          next_state_s = PASS;
        end
        default: begin
          clr_s        = 1'b1;
          next_state_s = PASS;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= PASS;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Split event counter, wraps naturally at 2^CW
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      split_count_r <= {CW{1'b0}};
    end else if (inc_s) begin
      split_count_r <= split_count_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      split_count_r <= split_count_r;
    end
  end

  mem_slot_reg #(.PW(PW)) u_out1 (
    .clk(CLK), .rst(RST), .en(out1_en_s), .clr(clr_s),
    .d_valid(d1_valid_s), .d_store(d1_store_s), .d_load(d1_load_s), .d_pay(d1_pay_s),
    .q_valid(OUT_valid1), .q_store(OUT_store1), .q_load(OUT_load1), .q_pay(OUT_pay1)
  );

  mem_slot_reg #(.PW(PW)) u_out2 (
    .clk(CLK), .rst(RST), .en(out2_en_s), .clr(clr_s),
    .d_valid(d2_valid_s), .d_store(d2_store_s), .d_load(d2_load_s), .d_pay(d2_pay_s),
    .q_valid(OUT_valid2), .q_store(OUT_store2), .q_load(OUT_load2), .q_pay(OUT_pay2)
  );

  // Hold slot captures the second store of a conflicting pair
  mem_slot_reg #(.PW(PW)) u_hold (
    .clk(CLK), .rst(RST), .en(hold_en_s), .clr(clr_s | hold_clr_s),
    .d_valid(IN_valid2), .d_store(IN_store2), .d_load(IN_load2), .d_pay(IN_pay2),
    .q_valid(hold_valid_s), .q_store(hold_store_s), .q_load(hold_load_s), .q_pay(hold_pay_s)
  );

endmodule

// File: tb/tb_mem_pair_split.sv
// Directed self-checking bench for mem_pair_split.
module tb_mem_pair_split;
  import mem_pair_split_pkg::*;

  localparam int PW = 96;
  localparam int CW = 32;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          FLUSH = 1'b0;
  logic          STALL_IN = 1'b0;
  logic          IN_valid1 = 1'b0, IN_valid2 = 1'b0;
  logic [1:0]    IN_store1 = 2'b00, IN_store2 = 2'b00;
  logic [2:0]    IN_load1 = 3'b000, IN_load2 = 3'b000;
  logic [PW-1:0] IN_pay1 = {PW{1'b0}}, IN_pay2 = {PW{1'b0}};
  logic          STALL_OUT, OUT_valid1, OUT_valid2;
  logic [1:0]    OUT_store1, OUT_store2;
  logic [2:0]    OUT_load1, OUT_load2;
  logic [PW-1:0] OUT_pay1, OUT_pay2;
  logic [CW-1:0] split_count;
  logic          s4_out, v4_1, v4_2;
  logic [1:0]    st4_1, st4_2;
  logic [2:0]    ld4_1, ld4_2;
  logic [PW-1:0] p4_1, p4_2;
  logic [3:0]    split_count4;

  int passed = 0;
  int total  = 0;
  int exp_cnt = 0;

  always #5 CLK = ~CLK;

  mem_pair_split #(.PW(PW), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .STALL_IN(STALL_IN), .STALL_OUT(STALL_OUT),
    .IN_valid1(IN_valid1), .IN_valid2(IN_valid2), .IN_store1(IN_store1), .IN_store2(IN_store2),
    .IN_load1(IN_load1), .IN_load2(IN_load2), .IN_pay1(IN_pay1), .IN_pay2(IN_pay2),
    .OUT_valid1(OUT_valid1), .OUT_valid2(OUT_valid2), .OUT_store1(OUT_store1), .OUT_store2(OUT_store2),
    .OUT_load1(OUT_load1), .OUT_load2(OUT_load2), .OUT_pay1(OUT_pay1), .OUT_pay2(OUT_pay2),
    .split_count(split_count)
  );

  // Narrow-counter build sharing the same stimulus, used for the wrap check
  mem_pair_split #(.PW(PW), .CW(4)) dut4 (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .STALL_IN(STALL_IN), .STALL_OUT(s4_out),
    .IN_valid1(IN_valid1), .IN_valid2(IN_valid2), .IN_store1(IN_store1), .IN_store2(IN_store2),
    .IN_load1(IN_load1), .IN_load2(IN_load2), .IN_pay1(IN_pay1), .IN_pay2(IN_pay2),
    .OUT_valid1(v4_1), .OUT_valid2(v4_2), .OUT_store1(st4_1), .OUT_store2(st4_2),
    .OUT_load1(ld4_1), .OUT_load2(ld4_2), .OUT_pay1(p4_1), .OUT_pay2(p4_2),
    .split_count(split_count4)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic v1, input logic [1:0] s1, input logic [2:0] l1, input logic [PW-1:0] p1,
                        input logic v2, input logic [1:0] s2, input logic [2:0] l2, input logic [PW-1:0] p2);
    IN_valid1 = v1; IN_store1 = s1; IN_load1 = l1; IN_pay1 = p1;
    IN_valid2 = v2; IN_store2 = s2; IN_load2 = l2; IN_pay2 = p2;
  endtask

  task automatic idle();
    set_in(1'b0, ST_NONE, LD_NONE, {PW{1'b0}}, 1'b0, ST_NONE, LD_NONE, {PW{1'b0}});
  endtask

  task automatic test_reset();
    set_in(1'b1, ST_SW, LD_LW, 96'h55, 1'b1, ST_SB, LD_LB, 96'h66);
    #1 RST = 1'b1;
    #2;
    total++; if ({OUT_valid1, OUT_valid2, OUT_store1, OUT_store2, OUT_load1, OUT_load2} !== 12'h000)
      $display("FAIL reset_ctl got %h exp 000", {OUT_valid1, OUT_valid2, OUT_store1, OUT_store2, OUT_load1, OUT_load2}); else passed++;
    total++; if ({OUT_pay1, OUT_pay2} !== {2*PW{1'b0}}) $display("FAIL reset_pay got %h/%h exp 0", OUT_pay1, OUT_pay2); else passed++;
    total++; if (split_count !== 32'd0) $display("FAIL reset_cnt got %0d exp 0", split_count); else passed++;
    step();
    total++; if (STALL_OUT !== 1'b0 || OUT_valid1 !== 1'b0) $display("FAIL reset_hold got stall=%b v1=%b exp 0 0", STALL_OUT, OUT_valid1); else passed++;
    RST = 1'b0;
    idle();
    step();
  endtask

  task automatic test_pass();
    set_in(1'b1, ST_SW, LD_NONE, 96'h100, 1'b1, ST_NONE, LD_LW, 96'h104);
    step();
    total++; if ({OUT_valid1, OUT_store1, OUT_load1} !== {1'b1, ST_SW, LD_NONE} || OUT_pay1 !== 96'h100)
      $display("FAIL pass_slot1 got v=%b s=%b l=%b p=%h exp 1 11 000 100", OUT_valid1, OUT_store1, OUT_load1, OUT_pay1); else passed++;
    total++; if ({OUT_valid2, OUT_store2, OUT_load2} !== {1'b1, ST_NONE, LD_LW} || OUT_pay2 !== 96'h104)
      $display("FAIL pass_slot2 got v=%b s=%b l=%b p=%h exp 1 00 011 104", OUT_valid2, OUT_store2, OUT_load2, OUT_pay2); else passed++;
    total++; if (STALL_OUT !== 1'b0 || split_count !== 32'd0)
      $display("FAIL pass_stall_cnt got %b/%0d exp 0/0", STALL_OUT, split_count); else passed++;
    // Invalid slot with store/load fields set must come out with them zeroed
    set_in(1'b0, ST_SW, LD_LH, 96'h7, 1'b1, ST_NONE, LD_LBU, 96'h8);
    step();
    total++; if ({OUT_valid1, OUT_store1, OUT_load1} !== 6'b0)
      $display("FAIL mask_slot1 got v=%b s=%b l=%b exp 0 00 000", OUT_valid1, OUT_store1, OUT_load1); else passed++;
    total++; if ({OUT_valid2, OUT_load2} !== {1'b1, LD_LBU} || split_count !== 32'd0)
      $display("FAIL mask_slot2 got v=%b l=%b cnt=%0d exp 1 100 0", OUT_valid2, OUT_load2, split_count); else passed++;
  endtask

  task automatic test_split();
    set_in(1'b1, ST_SW, LD_NONE, 96'hA, 1'b1, ST_SB, LD_NONE, 96'hB);
    step();
    exp_cnt++;
    total++; if ({OUT_valid1, OUT_store1} !== {1'b1, ST_SW} || OUT_pay1 !== 96'hA)
      $display("FAIL split_c1_slot1 got v=%b s=%b p=%h exp 1 11 a", OUT_valid1, OUT_store1, OUT_pay1); else passed++;
    total++; if ({OUT_valid2, OUT_store2, OUT_load2, STALL_OUT} !== 7'b0000001)
      $display("FAIL split_c1_slot2 got v=%b s=%b l=%b stall=%b exp 0 00 000 1", OUT_valid2, OUT_store2, OUT_load2, STALL_OUT); else passed++;
    // Next pair is presented during SPLIT and must wait
    set_in(1'b1, ST_NONE, LD_LW, 96'hC, 1'b1, ST_NONE, LD_LB, 96'hD);
    step();
    total++; if ({OUT_valid1, OUT_store1, OUT_load1} !== 6'b0)
      $display("FAIL split_c2_slot1 got v=%b s=%b l=%b exp 0 00 000", OUT_valid1, OUT_store1, OUT_load1); else passed++;
    total++; if ({OUT_valid2, OUT_store2} !== {1'b1, ST_SB} || OUT_pay2 !== 96'hB || STALL_OUT !== 1'b0)
      $display("FAIL split_c2_slot2 got v=%b s=%b p=%h stall=%b exp 1 01 b 0", OUT_valid2, OUT_store2, OUT_pay2, STALL_OUT); else passed++;
    total++; if (split_count !== 32'd1) $display("FAIL split_cnt got %0d exp 1", split_count); else passed++;
    step();
    total++; if (OUT_valid1 !== 1'b1 || OUT_pay1 !== 96'hC || OUT_valid2 !== 1'b1 || OUT_pay2 !== 96'hD)
      $display("FAIL split_held_pair got %b %h %b %h exp 1 c 1 d", OUT_valid1, OUT_pay1, OUT_valid2, OUT_pay2); else passed++;
    idle();
  endtask

  task automatic test_back_to_back();
    set_in(1'b1, ST_SW, LD_NONE, 96'h11, 1'b1, ST_SH, LD_NONE, 96'h22);
    step();
    total++; if (OUT_valid1 !== 1'b1 || OUT_pay1 !== 96'h11 || OUT_valid2 !== 1'b0)
      $display("FAIL b2b_c1 got %b %h %b exp 1 11 0", OUT_valid1, OUT_pay1, OUT_valid2); else passed++;
    set_in(1'b1, ST_SB, LD_NONE, 96'h33, 1'b1, ST_SW, LD_NONE, 96'h44);
    step();
    total++; if (OUT_valid1 !== 1'b0 || OUT_valid2 !== 1'b1 || OUT_pay2 !== 96'h22 || OUT_store2 !== ST_SH)
      $display("FAIL b2b_c2 got %b %b %h %b exp 0 1 22 10", OUT_valid1, OUT_valid2, OUT_pay2, OUT_store2); else passed++;
    step();
    total++; if (OUT_valid1 !== 1'b1 || OUT_pay1 !== 96'h33 || OUT_valid2 !== 1'b0 || STALL_OUT !== 1'b1)
      $display("FAIL b2b_c3 got %b %h %b stall=%b exp 1 33 0 1", OUT_valid1, OUT_pay1, OUT_valid2, STALL_OUT); else passed++;
    idle();
    step();
    exp_cnt += 2;
    total++; if (OUT_valid1 !== 1'b0 || OUT_valid2 !== 1'b1 || OUT_pay2 !== 96'h44 || OUT_store2 !== ST_SW)
      $display("FAIL b2b_c4 got %b %b %h %b exp 0 1 44 11", OUT_valid1, OUT_valid2, OUT_pay2, OUT_store2); else passed++;
    total++; if (split_count !== 32'(exp_cnt)) $display("FAIL b2b_cnt got %0d exp %0d", split_count, exp_cnt); else passed++;
  endtask

  task automatic test_flush();
    set_in(1'b1, ST_SW, LD_NONE, 96'h55, 1'b1, ST_SW, LD_NONE, 96'h66);
    step();
    exp_cnt++;
    idle();
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    total++; if ({OUT_valid1, OUT_valid2, OUT_store1, OUT_store2, STALL_OUT} !== 7'b0)
      $display("FAIL flush_out got v=%b%b s=%b%b stall=%b exp 0", OUT_valid1, OUT_valid2, OUT_store1, OUT_store2, STALL_OUT); else passed++;
    total++; if (split_count !== 32'(exp_cnt)) $display("FAIL flush_cnt got %0d exp %0d", split_count, exp_cnt); else passed++;
    step();
    total++; if (OUT_valid2 !== 1'b0 || OUT_valid1 !== 1'b0) $display("FAIL flush_held_dropped got %b %b exp 0 0", OUT_valid1, OUT_valid2); else passed++;
  endtask

  task automatic test_stall();
    set_in(1'b1, ST_SH, LD_NONE, 96'h77, 1'b1, ST_SB, LD_NONE, 96'h88);
    step();
    exp_cnt++;
    idle();
    STALL_IN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (OUT_valid1 !== 1'b1 || OUT_pay1 !== 96'h77 || OUT_valid2 !== 1'b0 || STALL_OUT !== 1'b1)
        $display("FAIL stall_frozen_%0d got %b %h %b stall=%b exp 1 77 0 1", i, OUT_valid1, OUT_pay1, OUT_valid2, STALL_OUT); else passed++;
    end
    STALL_IN = 1'b0;
    #1;
    total++; if (STALL_OUT !== 1'b1) $display("FAIL stall_state_split got %b exp 1", STALL_OUT); else passed++;
    step();
    total++; if (OUT_valid1 !== 1'b0 || OUT_valid2 !== 1'b1 || OUT_pay2 !== 96'h88 || STALL_OUT !== 1'b0)
      $display("FAIL stall_release got %b %b %h stall=%b exp 0 1 88 0", OUT_valid1, OUT_valid2, OUT_pay2, STALL_OUT); else passed++;
    total++; if (split_count !== 32'(exp_cnt)) $display("FAIL stall_cnt got %0d exp %0d", split_count, exp_cnt); else passed++;
  endtask

  task automatic do_split();
    set_in(1'b1, ST_SB, LD_NONE, 96'h1, 1'b1, ST_SB, LD_NONE, 96'h2);
    step();
    idle();
    step();
    exp_cnt++;
  endtask

  task automatic test_wrap();
    while (exp_cnt < 15) do_split();
    total++; if (split_count4 !== 4'd15 || split_count !== 32'd15)
      $display("FAIL wrap_pre got %0d/%0d exp 15/15", split_count4, split_count); else passed++;
    do_split();
    total++; if (split_count4 !== 4'd0) $display("FAIL wrap_cw4 got %0d exp 0", split_count4); else passed++;
    total++; if (split_count !== 32'd16) $display("FAIL wrap_cw32 got %0d exp 16", split_count); else passed++;
  endtask

  task automatic test_reset_mid_split();
    set_in(1'b1, ST_SW, LD_NONE, 96'h99, 1'b1, ST_SW, LD_NONE, 96'hAA);
    step();
    idle();
    RST = 1'b1;
    #2;
    total++; if ({OUT_valid1, OUT_valid2, STALL_OUT} !== 3'b000 || OUT_pay1 !== {PW{1'b0}} || split_count !== 32'd0)
      $display("FAIL rst_mid_async got %b%b stall=%b p=%h cnt=%0d exp 0", OUT_valid1, OUT_valid2, STALL_OUT, OUT_pay1, split_count); else passed++;
    RST = 1'b0;
    step();
    total++; if (OUT_valid1 !== 1'b0 || OUT_valid2 !== 1'b0 || STALL_OUT !== 1'b0)
      $display("FAIL rst_mid_dropped got %b %b stall=%b exp 0 0 0", OUT_valid1, OUT_valid2, STALL_OUT); else passed++;
    set_in(1'b1, ST_NONE, LD_LHU, 96'hBB, 1'b0, ST_NONE, LD_NONE, 96'h0);
    step();
    total++; if (OUT_valid1 !== 1'b1 || OUT_load1 !== LD_LHU || OUT_pay1 !== 96'hBB)
      $display("FAIL rst_mid_pass got %b %b %h exp 1 101 bb", OUT_valid1, OUT_load1, OUT_pay1); else passed++;
  endtask

  initial begin
    test_reset();
    test_pass();
    test_split();
    test_back_to_back();
    test_flush();
    test_stall();
    test_wrap();
    test_reset_mid_split();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_pair_split.md
MEM_PAIR_SPLIT -- requirements
Module: mem_pair_split

Interface
REQ-001 SHALL have parameter PW, default 96, meaning width of the opaque per-slot payload (operands, rd, PC).
REQ-002 SHALL have parameter CW, default 32, meaning width of the split event counter.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 CLK  in  1  clock; all state updates on rising edge.
REQ-005 RST  in  1  asynchronous active-high reset.
REQ-006 FLUSH  in  1  kill all in-flight slots (branch redirect).
REQ-007 STALL_IN  in  1  downstream hold; freeze all registers.
REQ-008 STALL_OUT  out  1  upstream hold request.
REQ-009 IN_valid1, IN_valid2  in  1 each  slot valid from C stage.
REQ-010 IN_store1, IN_store2  in  2 each  01 SB, 10 SH, 11 SW, 00 not store.
REQ-011 IN_load1, IN_load2  in  3 each  001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, 000 not load.
REQ-012 IN_pay1, IN_pay2  in  PW each  opaque payload.
REQ-013 OUT_valid1/2, OUT_store1/2, OUT_load1/2, OUT_pay1/2  out  same widths  registered slot outputs to E stage.
REQ-014 split_count  out  CW  number of store-pair splits performed.

Function
REQ-015 SHALL define conflict = IN_valid1 & IN_valid2 & (IN_store1!=00) & (IN_store2!=00).
REQ-016 SHALL have two states, PASS and SPLIT, in a registered state variable.
REQ-017 PASS, no conflict, no STALL_IN: both input slots SHALL be registered to outputs unchanged; latency exactly 1 cycle.
REQ-018 PASS, conflict, no STALL_IN: slot1 SHALL go to OUT slot1; OUT_valid2=0, OUT_store2=00, OUT_load2=000; slot2 captured into hold register; next state SPLIT.
REQ-019 SPLIT, no STALL_IN: OUT_valid1=0 with OUT_store1/load1 zero; held slot2 emitted on OUT slot2; inputs ignored; next state PASS.
REQ-020 STALL_OUT SHALL equal (state==SPLIT) | STALL_IN, combinational from registers and STALL_IN only; no path from IN_* to STALL_OUT.
REQ-021 The upstream pair presented during SPLIT SHALL be held by upstream and accepted in the following PASS cycle.
REQ-022 Whenever an OUT_valid is 0, the matching OUT_store and OUT_load SHALL be 0; payload is don't-care but SHALL be 0 after reset.
REQ-023 Input slots with IN_valid=0 SHALL be emitted with store/load fields forced to 0.
REQ-024 STALL_IN=1 and FLUSH=0: all output registers, the hold register, the state and split_count SHALL keep their values.
REQ-025 FLUSH=1: next cycle OUT_valid1/2=0, store/load=0, state=PASS, hold discarded, split_count unchanged; FLUSH SHALL take priority over STALL_IN and conflict.
REQ-026 split_count SHALL increment by 1 on each PASS->SPLIT transition and wrap modulo 2^CW.
REQ-027 A conflict pair arriving in the PASS cycle directly after SPLIT SHALL split again; back-to-back splits have no bubble beyond REQ-019.
REQ-028 Load/store address-hazard resolution is out of scope; downstream memory handles store-then-load forwarding.

Reset
REQ-029 While RST=1: state=PASS, all OUT_* =0, hold register=0, split_count=0, STALL_OUT=0 except as STALL_IN requires.
REQ-030 RST asserted mid-SPLIT SHALL drop the held slot; first post-reset edge behaves as PASS.

Structure
REQ-031 Store and load encodings SHALL be shared constants in define.vh (package), not literals.
REQ-032 One sub-module, mem_slot_reg (valid/store/load/payload register with load-enable and clear), SHALL be instantiated for OUT slot1, OUT slot2 and the hold slot.
REQ-033 Block SHALL be synthesizable, no latches, single clock domain.

Verification
REQ-034 Pair SW@0x100 + LW@0x104 in PASS -> one cycle later both slots out unchanged, STALL_OUT=0, split_count=0.
REQ-035 Pair SW(pay=0xA) + SB(pay=0xB) -> cycle1 OUT slot1 pay=0xA, OUT_valid2=0, STALL_OUT=1; cycle2 OUT_valid1=0, OUT slot2 pay=0xB, STALL_OUT=0; split_count=1.
REQ-036 Two consecutive store pairs -> four output cycles alternating slot1-only/slot2-only, split_count=2, no pair lost or duplicated.
REQ-037 Conflict pair then FLUSH=1 in SPLIT cycle -> next cycle all OUT_valid=0, state PASS, held slot never emitted, split_count=1.
REQ-038 STALL_IN=1 for 3 cycles during SPLIT -> outputs, STALL_OUT=1 and state frozen; held slot emitted one cycle after STALL_IN drops.
REQ-039 split_count preloaded via CW=4 build to 15, one split -> reads 0; RST pulse mid-SPLIT -> all outputs 0 asynchronously.
